// File: rtl/step_rate_gen.sv
// step_rate_gen -- turns a speed code into a periodic one-cycle step strobe
// for the stepper phase sequencer. It supports continuous running (auto_en)
// and counted moves of move_steps full steps, with a start/busy/done
// handshake and a stop/abort input.
//
// Optional feature: define STEP_RAMP_EN to enable an acceleration ramp.
// With the ramp, the first interval is max(RAMP_START, T), and each step
// shortens the interval by RAMP_DEC until it reaches T.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   speed_value  speed code; all-ones is fastest
//   half_step    1 = half-step mode (halves the period, doubles move length)
//   auto_en      1 = continuous run
//   start        one-cycle request for a counted move
//   move_steps   move length in full steps
//   stop         abort current activity (highest priority)
//   step_pulse   one-cycle step strobe
//   busy         high while in RUN or MOVE
//   done         one-cycle move-complete strobe
//
// state | meaning
// IDLE  | counter held at 0, waiting for auto_en or start
// RUN   | continuous stepping until auto_en drops or stop
// MOVE  | counted move; returns to IDLE after the final step or on abort
module step_rate_gen #(
    parameter int CNT_W       = 24,
    parameter int SPEED_W     = 4,
    parameter int BASE_PERIOD = 500000,
    parameter int PERIOD_STEP = 100000,
    parameter int MOVE_W      = 12,
    parameter int RAMP_START  = 2000000,
    parameter int RAMP_DEC    = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SPEED_W-1:0] speed_value,
    input  logic               half_step,
    input  logic               auto_en,
    input  logic               start,
    input  logic [MOVE_W-1:0]  move_steps,
    input  logic               stop,
    output logic               step_pulse,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, RUN, MOVE} state_t;

    localparam logic [63:0] BASE_W  = 64'(BASE_PERIOD);
    localparam logic [63:0] STEP_W  = 64'(PERIOD_STEP);
    localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});
`ifdef STEP_RAMP_EN
    localparam logic [CNT_W-1:0] RAMP_S = CNT_W'(RAMP_START);
    localparam logic [CNT_W-1:0] RAMP_D = CNT_W'(RAMP_DEC);
`endif

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [CNT_W-1:0]  period, period_nxt;
    logic [MOVE_W:0]   remaining, remaining_nxt;
    logic              move_half, move_half_nxt;
    logic              zero_done, zero_done_nxt;
    logic              pulse, move_done;

    logic [SPEED_W-1:0] speed_gap;
    logic [63:0]        t_raw, t_half;
    logic               half_eff;
    logic [CNT_W-1:0]   target, entry_period, relatch_period;

    // half_step is frozen for the duration of a counted move
    assign half_eff  = (state == MOVE) ? move_half : half_step;
    assign speed_gap = ~speed_value;

    // Target period; the arithmetic is done wide so that overflow can be
    // detected and saturated instead of silently wrapping.
    always_comb begin
        t_raw  = BASE_W + 64'(speed_gap) * STEP_W;
        t_half = half_eff ? (t_raw >> 1) : t_raw;
        if (t_half > CNT_MAX)
            target = '1;
        else
            target = t_half[CNT_W-1:0];
        if (target < CNT_W'(2))
            target = CNT_W'(2);
    end

    always_comb begin
        entry_period   = target;
        relatch_period = target;
`ifdef STEP_RAMP_EN
        entry_period = (RAMP_S > target) ? RAMP_S : target;
        // A rising target is taken immediately; only a falling one is ramped.
        if (period > target && (period - target) > RAMP_D)
            relatch_period = period - RAMP_D;
`endif
    end

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        period_nxt    = period;
        remaining_nxt = remaining;
        move_half_nxt = move_half;
        zero_done_nxt = 1'b0;
        pulse         = 1'b0;
        move_done     = 1'b0;
        case (state)
            IDLE: begin
                count_nxt = '0;
                if (!stop) begin
                    if (auto_en) begin
                        state_nxt  = RUN;
                        period_nxt = entry_period;
                    end else if (start) begin
                        if (move_steps == '0) begin
                            zero_done_nxt = 1'b1;
                        end else begin
                            state_nxt     = MOVE;
                            period_nxt    = entry_period;
                            move_half_nxt = half_step;
                            remaining_nxt = half_step ? {move_steps, 1'b0}
                                                      : {1'b0, move_steps};
                        end
                    end
                end
            end
            RUN: begin
                if (stop || !auto_en) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end else if (count == period - CNT_W'(1)) begin
                    pulse      = 1'b1;
                    count_nxt  = '0;
                    period_nxt = relatch_period;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            MOVE: begin
                // Abort wins over a would-be step, including the final one.
                if (stop || auto_en) begin
                    state_nxt     = IDLE;
                    count_nxt     = '0;
                    remaining_nxt = '0;
                end else if (count == period - CNT_W'(1)) begin
                    pulse         = 1'b1;
                    count_nxt     = '0;
                    period_nxt    = relatch_period;
                    remaining_nxt = remaining - (MOVE_W+1)'(1);
                    if (remaining == (MOVE_W+1)'(1)) begin
                        move_done = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            period    <= '0;
            remaining <= '0;
            move_half <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            period    <= period_nxt;
            remaining <= remaining_nxt;
            move_half <= move_half_nxt;
            zero_done <= zero_done_nxt;
        end
    end

    assign step_pulse = pulse;
    assign busy       = (state != IDLE);
    assign done       = move_done | zero_done;

endmodule

// File: tb/tb_step_rate_gen.sv
module tb_step_rate_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  speed_value;
    logic        half_step, auto_en, start, stop;
    logic [11:0] move_steps;
    logic        step_pulse, busy, done;

    logic        clamp_half, clamp_auto;
    logic        clamp_pulse, clamp_busy, clamp_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    step_rate_gen #(
        .CNT_W(24), .SPEED_W(4), .BASE_PERIOD(10), .PERIOD_STEP(2),
        .MOVE_W(12), .RAMP_START(30), .RAMP_DEC(5)
    ) u_dut (
        .clk(clk), .rst(rst), .speed_value(speed_value), .half_step(half_step),
        .auto_en(auto_en), .start(start), .move_steps(move_steps), .stop(stop),
        .step_pulse(step_pulse), .busy(busy), .done(done)
    );

    step_rate_gen #(
        .CNT_W(24), .SPEED_W(4), .BASE_PERIOD(3), .PERIOD_STEP(0), .MOVE_W(12)
    ) u_clamp (
        .clk(clk), .rst(rst), .speed_value(4'hF), .half_step(clamp_half),
        .auto_en(clamp_auto), .start(1'b0), .move_steps(12'd0), .stop(1'b0),
        .step_pulse(clamp_pulse), .busy(clamp_busy), .done(clamp_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts negedges until the selected strobe is seen; -1 if budget expires.
    task automatic wait_pulse(input bit sel, input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            n++;
            if ((sel ? clamp_pulse : step_pulse) === 1'b1) return;
        end
        n = -1;
    endtask

    // Launches a counted move and observes it until busy drops.
    task automatic run_move(input int steps, input bit half, input int budget,
                            output int pulses, output int dones,
                            output int done_at, output int gap);
        int done_idx;
        @(posedge clk); #1;
        half_step  = half;
        move_steps = 12'(steps);
        start      = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        pulses   = 0;
        dones    = 0;
        done_at  = -1;
        done_idx = -1;
        gap      = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (step_pulse === 1'b1) pulses++;
            if (done === 1'b1) begin
                dones++;
                done_at  = pulses;
                done_idx = i;
            end
            if (busy !== 1'b1) begin
                gap = i - done_idx;
                break;
            end
        end
        half_step = 1'b0;
    endtask

    initial begin
        int n, p, d, da, g;
        rst = 1'b0; speed_value = 4'hF; half_step = 1'b0; auto_en = 1'b0;
        start = 1'b0; stop = 1'b0; move_steps = 12'd0;
        clamp_half = 1'b0; clamp_auto = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_step_pulse", 32'(step_pulse), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1 rst = 1'b1;

`ifndef STEP_RAMP_EN
        // stop beats auto_en in IDLE
        @(posedge clk); #1 auto_en = 1'b1; stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
        check("stop_priority_busy", 32'(busy), 32'd0);
        @(posedge clk);
        wait_pulse(0, 60, n);  check("run_first", 32'(n), 32'd10);
        check("run_busy", 32'(busy), 32'd1);
        wait_pulse(0, 60, n);  check("run_second", 32'(n), 32'd10);
        @(posedge clk); #1 speed_value = 4'h0;
        wait_pulse(0, 60, n);  check("run_old_interval", 32'(n), 32'd10);
        wait_pulse(0, 60, n);  check("run_slow", 32'(n), 32'd40);
        @(posedge clk); #1 auto_en = 1'b0; speed_value = 4'hF;
        repeat (2) @(negedge clk);
        check("run_exit_busy", 32'(busy), 32'd0);

        // half-step continuous run: period 5
        @(posedge clk); #1 half_step = 1'b1; auto_en = 1'b1;
        @(posedge clk);
        wait_pulse(0, 60, n);  check("half_first", 32'(n), 32'd5);
        wait_pulse(0, 60, n);  check("half_second", 32'(n), 32'd5);
        @(posedge clk); #1 auto_en = 1'b0; half_step = 1'b0;
        repeat (2) @(negedge clk);

        // minimum period clamp: T=3 full step, 3>>1=1 clamps to 2
        @(posedge clk); #1 clamp_auto = 1'b1;
        @(posedge clk);
        wait_pulse(1, 60, n);  check("clamp_full", 32'(n), 32'd3);
        @(posedge clk); #1 clamp_half = 1'b1;
        wait_pulse(1, 60, n);  check("clamp_old_interval", 32'(n), 32'd3);
        wait_pulse(1, 60, n);  check("clamp_half_a", 32'(n), 32'd2);
        wait_pulse(1, 60, n);  check("clamp_half_b", 32'(n), 32'd2);
        @(posedge clk); #1 clamp_auto = 1'b0; clamp_half = 1'b0;

        // counted moves
        run_move(50, 1'b0, 700, p, d, da, g);
        check("move50_pulses", 32'(p), 32'd50);
        check("move50_dones", 32'(d), 32'd1);
        check("move50_done_at", 32'(da), 32'd50);
        check("move50_busy_gap", 32'(g), 32'd1);
        run_move(50, 1'b1, 700, p, d, da, g);
        check("move100_pulses", 32'(p), 32'd100);
        check("move100_dones", 32'(d), 32'd1);
        check("move100_done_at", 32'(da), 32'd100);
        check("move100_busy_gap", 32'(g), 32'd1);

        // zero-length move
        @(posedge clk); #1 move_steps = 12'd0; start = 1'b1;
        @(negedge clk);
        check("zero_done_early", 32'(done), 32'd0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        p = 0; d = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (step_pulse === 1'b1) p++;
            if (done === 1'b1 || busy === 1'b1) d++;
        end
        check("zero_no_pulse", 32'(p), 32'd0);
        check("zero_quiet_after", 32'(d), 32'd0);

        // stop after the 7th pulse of a 50-step move
        @(posedge clk); #1 move_steps = 12'd50; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 7; i++) wait_pulse(0, 30, n);
        check("stop_seventh_interval", 32'(n), 32'd10);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
        check("stop_idle", 32'(busy), 32'd0);
        p = 0; d = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (step_pulse === 1'b1) p++;
            if (done === 1'b1) d++;
        end
        check("stop_no_pulse", 32'(p), 32'd0);
        check("stop_no_done", 32'(d), 32'd0);

        // auto_en abort landing on the would-be final pulse
        @(posedge clk); #1 move_steps = 12'd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_pulse(0, 30, n);
        repeat (10) @(posedge clk);
        #1 auto_en = 1'b1;
        @(negedge clk);
        check("abort_final_pulse", 32'(step_pulse), 32'd0);
        check("abort_final_done", 32'(done), 32'd0);
        @(posedge clk); #1 auto_en = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);

        // asynchronous reset during the final pulse of a move
        @(posedge clk); #1 move_steps = 12'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 3; i++) wait_pulse(0, 30, n);
        check("rstmid_pre_done", 32'(done), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rstmid_step_pulse", 32'(step_pulse), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_after_busy", 32'(busy), 32'd0);
`else
        // acceleration ramp: 30,25,20,15,10,10 with T=10
        @(posedge clk); #1 auto_en = 1'b1;
        @(posedge clk);
        wait_pulse(0, 60, n);  check("ramp_1", 32'(n), 32'd30);
        wait_pulse(0, 60, n);  check("ramp_2", 32'(n), 32'd25);
        wait_pulse(0, 60, n);  check("ramp_3", 32'(n), 32'd20);
        wait_pulse(0, 60, n);  check("ramp_4", 32'(n), 32'd15);
        wait_pulse(0, 60, n);  check("ramp_5", 32'(n), 32'd10);
        wait_pulse(0, 60, n);  check("ramp_6", 32'(n), 32'd10);
        @(posedge clk); #1 speed_value = 4'h0;
        wait_pulse(0, 60, n);  check("ramp_old_interval", 32'(n), 32'd10);
        @(posedge clk); #1 speed_value = 4'hF;
        wait_pulse(0, 60, n);  check("ramp_jump_up", 32'(n), 32'd40);
        wait_pulse(0, 60, n);  check("ramp_down_a", 32'(n), 32'd35);
        wait_pulse(0, 60, n);  check("ramp_down_b", 32'(n), 32'd30);
        @(posedge clk); #1 auto_en = 1'b0;
        repeat (2) @(negedge clk);
        check("ramp_exit_busy", 32'(busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
